// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: parametrised single-clock FIFO with a build-time choice of read
// mode. FWFT=0 gives a registered read with one cycle of latency. FWFT=1 shows the
// head word combinationally, and rd_en pops it. The FIFO also provides an occupancy
// count, almost-full/almost-empty thresholds, a synchronous flush, and sticky
// overflow/underflow flags.
module sync_fifo_fwft #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       full,
  output logic                       almost_full,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Reject parameter sets the pointer arithmetic and threshold decodes cannot honour.
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_fwft: DATA_WIDTH must be >= 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_fwft: DEPTH must be a power of two and >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_fwft: AF_THRESH must lie in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_fwft: AE_THRESH must lie in 0..DEPTH-1");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
    $error("sync_fifo_fwft: FWFT must be 0 or 1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         level_next;
  logic                  wr_accept;
  logic                  rd_accept;

  // Status flags decode only the registered level, so request inputs have no path to them.
  assign full         = (level == LW'(DEPTH));
  assign empty        = (level == '0);
  assign almost_full  = (level >= LW'(AF_THRESH));
  assign almost_empty = (level <= LW'(AE_THRESH));

  // A flush drops both requests. A full FIFO refuses the write and an empty FIFO
  // refuses the read. This is how a simultaneous request at either boundary is settled.
  assign wr_accept = wr_en && !full  && !flush;
  assign rd_accept = rd_en && !empty && !flush;

  // Compute the next occupancy. A push and a pop in the same cycle cancel out.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    level_next = level;
    case ({wr_accept, rd_accept})
      2'b10:   level_next = level + 1'b1;
      2'b01:   level_next = level - 1'b1;
      default: level_next = level;
    endcase
  end

  // Write the storage array. It is deliberately left out of reset and flush.
  always_ff @(posedge clk) begin
    // NOTE: the data array has no reset; contents are only meaningful once level says so, and a reset term would stop RAM inference.
    if (wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Update the pointers, the level counter and the sticky error flags. Reset and flush clear them the same way.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level_next;
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  if (FWFT == 0) begin : g_registered_read
    // Registered read. Data and valid appear in the cycle after an accepted rd_en.
    // rd_data keeps its last value otherwise, including across a flush.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else if (flush) begin
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_accept;
        if (rd_accept) begin
          rd_data <= mem[rd_ptr];
        end
      end
    end
  end else begin : g_fall_through
    // Fall-through. The head entry is always on rd_data, and it is valid whenever the FIFO holds data.
    assign rd_data  = mem[rd_ptr];
    assign rd_valid = !empty;
  end

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb_sync_fifo_fwft: directed tests for sync_fifo_fwft. The bench uses three instances:
// registered read with default thresholds, fall-through, and registered read with
// AF=12/AE=3. Inputs change 1 ns after each rising edge, and outputs are sampled at
// that same point.
`timescale 1ns/1ps
module tb_sync_fifo_fwft;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Registered-read instance, defaults (AF=14, AE=2)
  logic       r_flush = 0, r_wr_en = 0, r_rd_en = 0;
  logic [7:0] r_wr_data = '0, r_rd_data;
  logic       r_full, r_af, r_empty, r_ae, r_rd_valid, r_ovf, r_udf;
  logic [4:0] r_level;

  // Fall-through instance
  logic       f_flush = 0, f_wr_en = 0, f_rd_en = 0;
  logic [7:0] f_wr_data = '0, f_rd_data;
  logic       f_full, f_af, f_empty, f_ae, f_rd_valid, f_ovf, f_udf;
  logic [4:0] f_level;

  // Threshold instance (AF=12, AE=3)
  logic       t_flush = 0, t_wr_en = 0, t_rd_en = 0;
  logic [7:0] t_wr_data = '0, t_rd_data;
  logic       t_full, t_af, t_empty, t_ae, t_rd_valid, t_ovf, t_udf;
  logic [4:0] t_level;

  sync_fifo_fwft #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) u_reg (
    .clk(clk), .rst(rst), .flush(r_flush), .wr_en(r_wr_en), .wr_data(r_wr_data),
    .full(r_full), .almost_full(r_af), .rd_en(r_rd_en), .rd_data(r_rd_data),
    .rd_valid(r_rd_valid), .empty(r_empty), .almost_empty(r_ae), .level(r_level),
    .overflow(r_ovf), .underflow(r_udf));

  sync_fifo_fwft #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .flush(f_flush), .wr_en(f_wr_en), .wr_data(f_wr_data),
    .full(f_full), .almost_full(f_af), .rd_en(f_rd_en), .rd_data(f_rd_data),
    .rd_valid(f_rd_valid), .empty(f_empty), .almost_empty(f_ae), .level(f_level),
    .overflow(f_ovf), .underflow(f_udf));

  sync_fifo_fwft #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0), .AF_THRESH(12), .AE_THRESH(3)) u_thr (
    .clk(clk), .rst(rst), .flush(t_flush), .wr_en(t_wr_en), .wr_data(t_wr_data),
    .full(t_full), .almost_full(t_af), .rd_en(t_rd_en), .rd_data(t_rd_data),
    .rd_valid(t_rd_valid), .empty(t_empty), .almost_empty(t_ae), .level(t_level),
    .overflow(t_ovf), .underflow(t_udf));

  // Status bundles: {full, almost_full, empty, almost_empty, level, overflow, underflow}
  wire [10:0] r_status = {r_full, r_af, r_empty, r_ae, r_level, r_ovf, r_udf};
  wire [10:0] f_status = {f_full, f_af, f_empty, f_ae, f_level, f_ovf, f_udf};
  wire [10:0] t_status = {t_full, t_af, t_empty, t_ae, t_level, t_ovf, t_udf};
  localparam logic [10:0] RESET_STATUS = {1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    r_wr_en = 1'b1; r_wr_data = 8'hFF;
    step();
    step();
    checks++;
    if (r_status !== RESET_STATUS || r_rd_valid !== 1'b0 || r_rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_reg: status=%b rd_valid=%b rd_data=%h, expected status=%b rd_valid=0 rd_data=00",
               r_status, r_rd_valid, r_rd_data, RESET_STATUS);
    end
    checks++;
    if (f_status !== RESET_STATUS || f_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_fwft: status=%b rd_valid=%b, expected status=%b rd_valid=0",
               f_status, f_rd_valid, RESET_STATUS);
    end
    checks++;
    if (t_status !== RESET_STATUS) begin
      errors++;
      $display("FAIL reset_thr: status=%b, expected %b", t_status, RESET_STATUS);
    end
    rst = 1'b0;
    r_wr_en = 1'b0;
    step();
    checks++;
    if (r_status !== RESET_STATUS || r_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: status=%b rd_valid=%b, expected status=%b rd_valid=0",
               r_status, r_rd_valid, RESET_STATUS);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      r_wr_en = 1'b1; r_wr_data = 8'(i);
      step();
      checks++;
      if (r_level !== 5'(i + 1) || r_full !== (i == 15) || r_af !== (i + 1 >= 14) ||
          r_ae !== (i + 1 <= 2) || r_empty !== 1'b0 || r_rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL fill[%0d]: level=%0d full=%b af=%b ae=%b empty=%b rd_valid=%b, expected level=%0d full=%b af=%b ae=%b empty=0 rd_valid=0",
                 i, r_level, r_full, r_af, r_ae, r_empty, r_rd_valid, i + 1, (i == 15), (i + 1 >= 14), (i + 1 <= 2));
      end
    end
    r_wr_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      r_rd_en = 1'b1;
      step();
      checks++;
      if (r_rd_valid !== 1'b1 || r_rd_data !== 8'(i) || r_level !== 5'(15 - i) || r_empty !== (i == 15)) begin
        errors++;
        $display("FAIL drain[%0d]: rd_valid=%b rd_data=%h level=%0d empty=%b, expected rd_valid=1 rd_data=%h level=%0d empty=%b",
                 i, r_rd_valid, r_rd_data, r_level, r_empty, 8'(i), 15 - i, (i == 15));
      end
    end
    r_rd_en = 1'b0;
    step();
    checks++;
    if (r_rd_valid !== 1'b0 || r_rd_data !== 8'h0F || r_empty !== 1'b1 || r_ae !== 1'b1) begin
      errors++;
      $display("FAIL drain_idle: rd_valid=%b rd_data=%h empty=%b ae=%b, expected rd_valid=0 rd_data=0f empty=1 ae=1",
               r_rd_valid, r_rd_data, r_empty, r_ae);
    end
  endtask

  task automatic test_wrap();
    for (int round = 0; round < 3; round++) begin
      for (int k = 0; k < 10; k++) begin
        r_wr_en = 1'b1; r_wr_data = 8'(round * 10 + k);
        step();
      end
      r_wr_en = 1'b0;
      checks++;
      if (r_level !== 5'd10) begin
        errors++;
        $display("FAIL wrap_level[%0d]: level=%0d, expected 10", round, r_level);
      end
      for (int k = 0; k < 10; k++) begin
        r_rd_en = 1'b1;
        step();
        checks++;
        if (r_rd_valid !== 1'b1 || r_rd_data !== 8'(round * 10 + k)) begin
          errors++;
          $display("FAIL wrap_data[%0d]: rd_valid=%b rd_data=%0d, expected rd_valid=1 rd_data=%0d",
                   round * 10 + k, r_rd_valid, r_rd_data, round * 10 + k);
        end
      end
      r_rd_en = 1'b0;
      checks++;
      if (r_level !== 5'd0 || r_empty !== 1'b1) begin
        errors++;
        $display("FAIL wrap_empty[%0d]: level=%0d empty=%b, expected level=0 empty=1", round, r_level, r_empty);
      end
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 5; i++) begin
      r_wr_en = 1'b1; r_wr_data = 8'(100 + i);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      r_wr_en = 1'b1; r_rd_en = 1'b1; r_wr_data = 8'(105 + i);
      step();
      checks++;
      if (r_level !== 5'd5 || r_rd_valid !== 1'b1 || r_rd_data !== 8'(100 + i)) begin
        errors++;
        $display("FAIL simul[%0d]: level=%0d rd_valid=%b rd_data=%0d, expected level=5 rd_valid=1 rd_data=%0d",
                 i, r_level, r_rd_valid, r_rd_data, 100 + i);
      end
    end
    r_wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      r_rd_en = 1'b1;
      step();
      checks++;
      if (r_rd_data !== 8'(120 + i)) begin
        errors++;
        $display("FAIL simul_drain[%0d]: rd_data=%0d, expected %0d", i, r_rd_data, 120 + i);
      end
    end
    r_rd_en = 1'b0;
    // Full FIFO with both requests: the read wins, the write is refused and flagged
    for (int i = 0; i < 16; i++) begin
      r_wr_en = 1'b1; r_wr_data = 8'(8'h40 + i);
      step();
    end
    r_wr_en = 1'b1; r_rd_en = 1'b1; r_wr_data = 8'hEE;
    step();
    checks++;
    if (r_level !== 5'd15 || r_ovf !== 1'b1 || r_udf !== 1'b0 || r_full !== 1'b0 || r_rd_data !== 8'h40) begin
      errors++;
      $display("FAIL full_wr_rd: level=%0d ovf=%b udf=%b full=%b rd_data=%h, expected level=15 ovf=1 udf=0 full=0 rd_data=40",
               r_level, r_ovf, r_udf, r_full, r_rd_data);
    end
    r_wr_en = 1'b0;
    for (int i = 0; i < 15; i++) begin
      r_rd_en = 1'b1;
      step();
      checks++;
      if (r_rd_data !== 8'(8'h41 + i)) begin
        errors++;
        $display("FAIL full_drain[%0d]: rd_data=%h, expected %h", i, r_rd_data, 8'(8'h41 + i));
      end
    end
    // Empty FIFO with both requests: the write wins, the read is refused and flagged
    r_wr_en = 1'b1; r_rd_en = 1'b1; r_wr_data = 8'h77;
    step();
    checks++;
    if (r_level !== 5'd1 || r_udf !== 1'b1 || r_ovf !== 1'b1 || r_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_wr_rd: level=%0d udf=%b ovf=%b rd_valid=%b, expected level=1 udf=1 ovf=1 rd_valid=0",
               r_level, r_udf, r_ovf, r_rd_valid);
    end
    r_wr_en = 1'b0; r_rd_en = 1'b1;
    step();
    r_rd_en = 1'b0;
    checks++;
    if (r_rd_valid !== 1'b1 || r_rd_data !== 8'h77 || r_level !== 5'd0) begin
      errors++;
      $display("FAIL empty_followup: rd_valid=%b rd_data=%h level=%0d, expected rd_valid=1 rd_data=77 level=0",
               r_rd_valid, r_rd_data, r_level);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 7; i++) begin
      r_wr_en = 1'b1; r_wr_data = 8'(8'h50 + i);
      step();
    end
    checks++;
    if (r_level !== 5'd7 || r_ovf !== 1'b1 || r_udf !== 1'b1) begin
      errors++;
      $display("FAIL preflush: level=%0d ovf=%b udf=%b, expected level=7 ovf=1 udf=1", r_level, r_ovf, r_udf);
    end
    r_flush = 1'b1; r_wr_en = 1'b1; r_rd_en = 1'b1; r_wr_data = 8'h99;
    step();
    checks++;
    if (r_status !== RESET_STATUS || r_rd_valid !== 1'b0 || r_rd_data !== 8'h77) begin
      errors++;
      $display("FAIL flush: status=%b rd_valid=%b rd_data=%h, expected status=%b rd_valid=0 rd_data=77",
               r_status, r_rd_valid, r_rd_data, RESET_STATUS);
    end
    r_flush = 1'b0; r_wr_en = 1'b0; r_rd_en = 1'b0;
    step();
    checks++;
    if (r_status !== RESET_STATUS) begin
      errors++;
      $display("FAIL flush_after: status=%b, expected %b", r_status, RESET_STATUS);
    end
    r_wr_en = 1'b1; r_wr_data = 8'h3C;
    step();
    r_wr_en = 1'b0; r_rd_en = 1'b1;
    step();
    r_rd_en = 1'b0;
    checks++;
    if (r_rd_valid !== 1'b1 || r_rd_data !== 8'h3C || r_level !== 5'd0) begin
      errors++;
      $display("FAIL flush_first_read: rd_valid=%b rd_data=%h level=%0d, expected rd_valid=1 rd_data=3c level=0",
               r_rd_valid, r_rd_data, r_level);
    end
    // Reset mid-stream also clears rd_data
    r_wr_en = 1'b1; r_wr_data = 8'h11;
    step();
    r_wr_data = 8'h22;
    step();
    r_wr_en = 1'b0; r_rd_en = 1'b1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; r_rd_en = 1'b0;
    checks++;
    if (r_status !== RESET_STATUS || r_rd_valid !== 1'b0 || r_rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_midstream: status=%b rd_valid=%b rd_data=%h, expected status=%b rd_valid=0 rd_data=00",
               r_status, r_rd_valid, r_rd_data, RESET_STATUS);
    end
  endtask

  task automatic test_fwft();
    f_wr_en = 1'b1; f_wr_data = 8'hA5;
    step();
    f_wr_en = 1'b0;
    checks++;
    if (f_rd_valid !== 1'b1 || f_rd_data !== 8'hA5 || f_level !== 5'd1 || f_empty !== 1'b0) begin
      errors++;
      $display("FAIL fwft_first: rd_valid=%b rd_data=%h level=%0d empty=%b, expected rd_valid=1 rd_data=a5 level=1 empty=0",
               f_rd_valid, f_rd_data, f_level, f_empty);
    end
    f_rd_en = 1'b1;
    step();
    f_rd_en = 1'b0;
    checks++;
    if (f_rd_valid !== 1'b0 || f_empty !== 1'b1) begin
      errors++;
      $display("FAIL fwft_pop: rd_valid=%b empty=%b, expected rd_valid=0 empty=1", f_rd_valid, f_empty);
    end
    f_wr_en = 1'b1; f_wr_data = 8'hB1;
    step();
    f_wr_data = 8'hB2;
    step();
    f_wr_en = 1'b0;
    checks++;
    if (f_rd_valid !== 1'b1 || f_rd_data !== 8'hB1 || f_level !== 5'd2) begin
      errors++;
      $display("FAIL fwft_head: rd_valid=%b rd_data=%h level=%0d, expected rd_valid=1 rd_data=b1 level=2",
               f_rd_valid, f_rd_data, f_level);
    end
    f_rd_en = 1'b1;
    step();
    checks++;
    if (f_rd_valid !== 1'b1 || f_rd_data !== 8'hB2) begin
      errors++;
      $display("FAIL fwft_next: rd_valid=%b rd_data=%h, expected rd_valid=1 rd_data=b2", f_rd_valid, f_rd_data);
    end
    step();
    step();
    f_rd_en = 1'b0;
    checks++;
    if (f_rd_valid !== 1'b0 || f_level !== 5'd0 || f_udf !== 1'b1 || f_ovf !== 1'b0) begin
      errors++;
      $display("FAIL fwft_underflow: rd_valid=%b level=%0d udf=%b ovf=%b, expected rd_valid=0 level=0 udf=1 ovf=0",
               f_rd_valid, f_level, f_udf, f_ovf);
    end
  endtask

  task automatic test_thresholds();
    for (int i = 0; i < 16; i++) begin
      t_wr_en = 1'b1; t_wr_data = 8'(i);
      if (i == 11) begin
        // The write request alone must not move almost_full before the edge
        #1;
        checks++;
        if (t_af !== 1'b0 || t_level !== 5'd11) begin
          errors++;
          $display("FAIL thr_no_comb_path: af=%b level=%0d, expected af=0 level=11", t_af, t_level);
        end
      end
      step();
      checks++;
      if (t_level !== 5'(i + 1) || t_ae !== (i + 1 <= 3) || t_af !== (i + 1 >= 12)) begin
        errors++;
        $display("FAIL thr_up[%0d]: level=%0d ae=%b af=%b, expected ae=%b af=%b",
                 i + 1, t_level, t_ae, t_af, (i + 1 <= 3), (i + 1 >= 12));
      end
    end
    t_wr_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      t_rd_en = 1'b1;
      step();
      checks++;
      if (t_level !== 5'(15 - i) || t_ae !== (15 - i <= 3) || t_af !== (15 - i >= 12) || t_rd_data !== 8'(i)) begin
        errors++;
        $display("FAIL thr_down[%0d]: level=%0d ae=%b af=%b rd_data=%0d, expected ae=%b af=%b rd_data=%0d",
                 15 - i, t_level, t_ae, t_af, t_rd_data, (15 - i <= 3), (15 - i >= 12), i);
      end
    end
    t_rd_en = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_fwft();
    test_thresholds();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion before 200000 ns");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sync_fifo_fwft.md
# sync_fifo_fwft

Parametrised synchronous FIFO, the successor to the CPU's basic single-clock FIFO. It selects at elaboration time between two read modes: registered read with one-cycle latency, or first-word fall-through (FWFT). It adds occupancy level, programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags. It sits between the RISC-V multicycle core and its peripherals (UART TX/RX, bus bridges) wherever elastic buffering is needed.

## Interface
- DATA_WIDTH, 8, entry width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- FWFT, 0, read mode: 0 = registered read, 1 = first-word fall-through
- AF_THRESH, DEPTH-2, almost_full asserts when level ≥ AF_THRESH; legal range 1..DEPTH
- AE_THRESH, 2, almost_empty asserts when level ≤ AE_THRESH; legal range 0..DEPTH-1
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous clear of contents/status; mem array untouched
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write data
- full  out  1  level == DEPTH
- almost_full  out  1  level ≥ AF_THRESH
- rd_en  in  1  read request (FWFT=1: pop/acknowledge of current head)
- rd_data  out  DATA_WIDTH  read data
- rd_valid  out  1  rd_data qualifier
- empty  out  1  level == 0
- almost_empty  out  1  level ≤ AE_THRESH
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH×DATA_WIDTH register array. wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap DEPTH-1→0 by natural overflow. level is a registered counter.
- Write accepted (wa) = wr_en && !full && !flush. On wa: mem[wr_ptr] ← wr_data, wr_ptr+1.
- Read accepted (ra) = rd_en && !empty && !flush. On ra: rd_ptr+1.
- level: +1 on wa only, −1 on ra only, unchanged on both or neither. It never exceeds DEPTH and never underflows.
- Full + wr_en + rd_en: the read is accepted and the write is rejected (overflow set). Empty + wr_en + rd_en: the write is accepted and the read is rejected (underflow set).
- full, empty, almost_full, almost_empty: combinational decodes of registered level only. There is no path from wr_en/rd_en to these outputs.
- FWFT=0: on ra at edge N, rd_data ← mem[rd_ptr] at edge N and rd_valid=1 for the cycle after N; otherwise rd_valid=0. rd_data holds its last value when there is no read.
- FWFT=1: rd_data = mem[rd_ptr] (asynchronous array read), rd_valid = !empty. An rd_en pulse consumes the displayed word.
- overflow ← 1 when wr_en && full && !flush. underflow ← 1 when rd_en && empty && !flush. Both hold until rst or flush.
- flush has priority over wr_en/rd_en in the same cycle: requests are dropped and not flagged. Pointers ← 0, level ← 0, overflow/underflow ← 0, rd_valid ← 0 (FWFT=0). rd_data holds in FWFT=0.
- rst: same as flush, and also rd_data ← 0 (FWFT=0). rst has priority over flush.
- Illegal parameters (non-power-of-two DEPTH, thresholds out of range) must stop elaboration via $error.

## Timing
- Reset values: full=0, almost_full=0, empty=1, almost_empty=1, level=0, overflow=0, underflow=0, rd_valid=0, rd_data=0 (FWFT=0; in FWFT=1 rd_data is don't-care while rd_valid=0).
- Status latency: flags and level reflect an accepted operation in the cycle after its edge.
- FWFT=0: read latency is 1 cycle (rd_en sampled at edge N → data/valid after N). Write→earliest read: write at edge N, empty=0 after N, read at edge N+1, data after N+1.
- FWFT=1: write into an empty FIFO at edge N → rd_valid=1 with that word immediately after N, zero added latency.
- Full throughput: one write and one read per cycle, sustained, with level constant.
- Reset or flush mid-stream: takes effect at that edge. The next cycle shows reset values, except mem, and rd_data in the FWFT=0 flush case.

## Test plan
- Reset, FWFT=0, DEPTH=16: write 0x00..0x0F on consecutive cycles → level 16, full=1, almost_full=1 from level 14. Read 16 → data 0x00..0x0F one cycle after each rd_en, empty=1 at end.
- Wrap-around: repeat 3 rounds of 10 writes/10 reads (values 0..29) → exact order preserved across pointer wrap, level returns to 0 each round.
- Simultaneous: preload 5, assert wr_en+rd_en for 20 cycles → level stays 5, output in order. At full, wr+rd → write dropped, overflow=1, level 15. At empty, wr+rd → read dropped, underflow=1, level 1.
- FWFT=1: write 0xA5 into empty FIFO → rd_valid=1, rd_data=0xA5 next cycle. rd_en → rd_valid=0, empty=1.
- Flush with level 7 and wr_en+rd_en high → next cycle level 0, empty=1, overflow/underflow=0, no flag set. A following write of 0x3C is the first read back.
- Thresholds AF_THRESH=12, AE_THRESH=3: sweep level 0→16→0 → almost_empty high for level ≤3, almost_full high for level ≥12, both cycle-exact.
